// File: rtl/shift_stage.sv
// Two-stage shift/rotate unit around an external 16-bit right rotator.
// Optional zero flag output enabled by defining SHIFT_STAGE_ZFLAG_EN.
module shift_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  input  logic [3:0]  in_cnt,
  input  logic [1:0]  in_op,
  input  logic [2:0]  in_tag,
  output logic [15:0] rot_in,
  output logic [3:0]  rot_cnt,
  input  logic [15:0] rot_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic [2:0]  out_tag
`ifdef SHIFT_STAGE_ZFLAG_EN
  ,
  output logic        out_zero
`endif
);

  localparam int unsigned DW = 16;
  localparam int unsigned CW = 4;
  localparam int unsigned TW = 3;

  typedef enum logic [1:0] {
    OP_ROL = 2'b00,
    OP_SLL = 2'b01,
    OP_ROR = 2'b10,
    OP_SRL = 2'b11
  } op_e;

  logic          a_valid;
  logic [DW-1:0] a_data;
  logic [CW-1:0] a_cnt;
  op_e           a_op;
  logic [TW-1:0] a_tag;

  logic          b_valid;
  logic [DW-1:0] b_data;
  logic [TW-1:0] b_tag;

  logic          adv_a;
  logic          adv_b;
  logic [DW-1:0] result;
  logic [DW-1:0] mask_l;
  logic [DW-1:0] mask_r;

  // Handshake: a stage may advance when the stage downstream is empty or moving.
  always_comb begin
    adv_b    = !b_valid || out_ready;
    adv_a    = !a_valid || adv_b;
    in_ready = adv_a;
  end

  // Left operations are right rotations by the complementary amount.
  always_comb begin
    rot_in = a_data;
    if (a_op == OP_ROR || a_op == OP_SRL) begin
      rot_cnt = a_cnt;
    end else begin
      rot_cnt = CW'(5'd16 - {1'b0, a_cnt});
    end
  end

  // Shifts are rotations with the wrapped-around bits cleared.
  always_comb begin
    mask_l = {DW{1'b1}} << a_cnt;
    mask_r = {DW{1'b1}} >> a_cnt;
    result = rot_out;
    case (a_op)
      OP_SLL:  result = rot_out & mask_l;
      OP_SRL:  result = rot_out & mask_r;
      default: result = rot_out;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_valid <= 1'b0;
      a_data  <= '0;
      a_cnt   <= '0;
      a_op    <= OP_ROL;
      a_tag   <= '0;
    end else if (adv_a) begin
      a_valid <= in_valid;
      if (in_valid) begin
        a_data <= in_data;
        a_cnt  <= in_cnt;
        a_op   <= op_e'(in_op);
        a_tag  <= in_tag;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_valid <= 1'b0;
      b_data  <= '0;
      b_tag   <= '0;
    end else if (adv_b) begin
      b_valid <= a_valid;
      if (a_valid) begin
        b_data <= result;
        b_tag  <= a_tag;
      end
    end
  end

`ifdef SHIFT_STAGE_ZFLAG_EN
  logic b_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_zero <= 1'b0;
    end else if (adv_b && a_valid) begin
      b_zero <= (result == '0);
    end
  end

  assign out_zero = b_zero;
`endif

  assign out_valid = b_valid;
  assign out_data  = b_data;
  assign out_tag   = b_tag;

endmodule
